instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: PC generation, credit-limited imem requests, response FIFO feeding decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect halts fetch and raises fetch_misaligned).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] IR,
  output logic [31:0] PC_out,
  output logic        IR_valid,
  input  logic        IR_ready,
  output logic        fetch_misaligned
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   pc_fetch_q, pc_fetch_d, pc_resp_q, pc_resp_d;
  logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   ir_mem_q [FIFO_DEPTH];
  logic [31:0]   ir_mem_d [FIFO_DEPTH];
  logic [31:0]   pc_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_d [FIFO_DEPTH];
  logic [31:0]   target_s;
  logic [CW:0]   inflight_s;
  logic          halted_s, grant_s, drop_s, push_s, pop_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halted_q, halted_d;
  assign target_s = redirect_pc;
  assign halted_s = halted_q;

  always_comb halted_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
`else
  assign target_s = redirect_pc & 32'hFFFF_FFFC;
  assign halted_s = 1'b0;
`endif

  // Credit covers both in-flight words and buffered words, so a response always finds a free slot.
  assign inflight_s = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req   = rst_n & (inflight_s < DEPTH_C) & ~redirect_valid & ~halted_s;
  assign imem_addr  = pc_fetch_q;

  assign IR_valid         = (count_q != {CW{1'b0}});
  assign IR               = IR_valid ? ir_mem_q[rd_ptr_q] : NOP;
  assign PC_out           = IR_valid ? pc_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign fetch_misaligned = halted_s;

  assign grant_s = imem_req & imem_gnt;
  assign drop_s  = imem_rvalid & (discard_q != {CW{1'b0}});
  assign push_s  = imem_rvalid & (discard_q == {CW{1'b0}}) & ~redirect_valid;
  assign pop_s   = IR_valid & IR_ready & ~redirect_valid;

  always_comb begin
    pc_fetch_d = pc_fetch_q;
    pc_resp_d  = pc_resp_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ir_mem_d   = ir_mem_q;
    pc_mem_d   = pc_mem_q;
    outst_d    = outst_q + CW'(grant_s) - CW'(imem_rvalid);
    count_d    = count_q + CW'(push_s) - CW'(pop_s);
    if (grant_s) pc_fetch_d = pc_fetch_q + 32'd4;
    if (drop_s)  discard_d  = discard_q - CW'(1'b1);
    if (push_s) begin
      ir_mem_d[wr_ptr_q] = imem_rdata;
      pc_mem_d[wr_ptr_q] = pc_resp_q;
      wr_ptr_d           = wr_ptr_q + AW'(1'b1);
      pc_resp_d          = pc_resp_q + 32'd4;
    end
    if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1'b1);
    // Every word still in flight after this cycle belongs to the abandoned stream.
    if (redirect_valid) begin
      pc_fetch_d = target_s;
      pc_resp_d  = target_s;
      discard_d  = outst_d;
      count_d    = {CW{1'b0}};
      wr_ptr_d   = {AW{1'b0}};
      rd_ptr_d   = {AW{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_fetch_q <= RESET_PC;
      pc_resp_q  <= RESET_PC;
      outst_q    <= {CW{1'b0}};
      discard_q  <= {CW{1'b0}};
      count_q    <= {CW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ir_mem_q[i] <= 32'h0000_0000;
        pc_mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      pc_fetch_q <= pc_fetch_d;
      pc_resp_q  <= pc_resp_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ir_mem_q   <= ir_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

`ifndef SYNTHESIS
  instr_fetch_unit_chk #(.CW(CW), .FIFO_DEPTH(FIFO_DEPTH)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_rvalid (imem_rvalid),
    .outst       (outst_q),
    .count       (count_q)
  );
`endif

endmodule

// Protocol checker: responses need a matching request, and the credit invariant must hold.
module instr_fetch_unit_chk #(
  parameter int CW         = 2,
  parameter int FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          imem_rvalid,
  input logic [CW-1:0] outst,
  input logic [CW-1:0] count
);
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rvalid && outst == {CW{1'b0}})) else $error("imem_rvalid with no outstanding request");
      assert ((32'(outst) + 32'(count)) <= 32'(FIFO_DEPTH)) else $error("outstanding + fifo_count exceeds depth");
    end
  end
endmodule
